// File: rtl/muldiv_sched.sv
// muldiv_sched: HI/LO multi-cycle scheduler for the EX stage (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MUL_DIV_MADD_EN to add the MADD (op 6) and MSUB (op 7) accumulate operations.
module muldiv_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_rd,
    input  logic        hilo_sel,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hilo_out
);
    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [63:0]   pend;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] div_s;
    logic [63:0] div_u;
    logic [63:0] result;
    logic        is_div;
    logic        is_long;

    always_comb begin
        prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
        // A zero divisor leaves HI/LO untouched, so the pending result is the current pair.
        div_s  = {hi, lo};
        div_u  = {hi, lo};
        if (rt_val != 32'd0) begin
            div_u = {rs_val % rt_val, rs_val / rt_val};
            if (rs_val == 32'h8000_0000 && rt_val == 32'hffff_ffff) begin
                div_s = {32'd0, 32'h8000_0000};
            end else begin
                div_s = {32'($signed(rs_val) % $signed(rt_val)),
                         32'($signed(rs_val) / $signed(rt_val))};
            end
        end

        result  = {hi, lo};
        is_div  = 1'b0;
        is_long = 1'b0;
        case (op)
            3'd0: begin result = prod_s; is_long = 1'b1; end
            3'd1: begin result = prod_u; is_long = 1'b1; end
            3'd2: begin result = div_s;  is_long = 1'b1; is_div = 1'b1; end
            3'd3: begin result = div_u;  is_long = 1'b1; is_div = 1'b1; end
`ifdef MUL_DIV_MADD_EN
            3'd6: begin result = {hi, lo} + prod_s; is_long = 1'b1; end
            3'd7: begin result = {hi, lo} - prod_s; is_long = 1'b1; end
`else
            3'd6, 3'd7: begin result = {hi, lo}; end
`endif
            default: begin result = {hi, lo}; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            pend  <= '0;
            busy  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                if (is_long) begin
                    pend  <= result;
                    cnt   <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
                    state <= RUN;
                    busy  <= 1'b1;
                end else if (op == 3'd4) begin
                    hi <= rs_val;
                end else if (op == 3'd5) begin
                    lo <= rs_val;
                end
            end
        end else begin
            // Commit on the last busy cycle so HI/LO are readable as busy falls.
            if (cnt == '0) begin
                hi    <= pend[63:32];
                lo    <= pend[31:0];
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign stall    = busy & (start | hilo_rd);
    assign hilo_out = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed cases plus random ops against a 64-bit arithmetic model.
module tb_muldiv_sched;
    localparam int MUL_CYCLES = 5;
    localparam int DIV_CYCLES = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_rd;
    logic        hilo_sel;
    logic        busy;
    logic        stall;
    logic [31:0] hilo_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] exp_q[$];

    muldiv_sched #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .hilo_rd(hilo_rd), .hilo_sel(hilo_sel), .busy(busy), .stall(stall), .hilo_out(hilo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of one request, from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        longint sa = $signed(a);
        longint sb = $signed(b);
        case (o)
            3'd0: return sa * sb;
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: if (b == 0) return acc; else return {32'(sa % sb), 32'(sa / sb)};
            3'd3: if (b == 0) return acc; else return {a % b, a / b};
            3'd4: return {a, acc[31:0]};
            3'd5: return {acc[63:32], a};
`ifdef MUL_DIV_MADD_EN
            3'd6: return acc + sa * sb;
            3'd7: return acc - sa * sb;
`endif
            default: return acc;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return MUL_CYCLES;
            3'd2, 3'd3: return DIV_CYCLES;
`ifdef MUL_DIV_MADD_EN
            3'd6, 3'd7: return MUL_CYCLES;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic read_hilo(input string tag);
        exp_q.push_back(m_lo);
        exp_q.push_back(m_hi);
        @(negedge clk);
        hilo_rd  = 1'b1;
        hilo_sel = 1'b0;
        #1 check({tag, "_lo"}, hilo_out, exp_q.pop_front());
        check({tag, "_rd_stall"}, {31'd0, stall}, 32'd0);
        hilo_sel = 1'b1;
        #1 check({tag, "_hi"}, hilo_out, exp_q.pop_front());
        hilo_rd = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] nxt;
        int lat;
        nxt = model(o, a, b, {m_hi, m_lo});
        lat = latency(o);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; hilo_sel = 1'b0;
        #1 check({tag, "_accept_stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            #1 check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_old_lo"}, hilo_out, m_lo);
            @(negedge clk);
        end
        #1 check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        m_hi = nxt[63:32];
        m_lo = nxt[31:0];
        read_hilo(tag);
    endtask

    // MULT with MFLO and a second request held from cycle 2 until stall releases.
    task automatic stall_case(input logic [31:0] a, input logic [31:0] b, input logic [31:0] mt);
        logic [63:0] nxt;
        nxt = model(3'd0, a, b, {m_hi, m_lo});
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = a; rt_val = b; hilo_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1 check("st_busy1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        hilo_rd = 1'b1; start = 1'b1; op = 3'd5; rs_val = mt;
        for (int c = 2; c <= MUL_CYCLES; c++) begin
            #1 check("st_stall", {31'd0, stall}, 32'd1);
            check("st_old_lo", hilo_out, m_lo);
            @(negedge clk);
        end
        m_hi = nxt[63:32];
        m_lo = nxt[31:0];
        #1 check("st_release", {31'd0, stall}, 32'd0);
        check("st_new_lo", hilo_out, m_lo);
        @(negedge clk);
        start = 1'b0; hilo_rd = 1'b0;
        m_lo = mt;
        #1 check("st_held_mtlo", hilo_out, m_lo);
        check("st_held_busy", {31'd0, busy}, 32'd0);
        read_hilo("st_after");
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; op = 3'd0; rs_val = '0; rt_val = '0;
        hilo_rd = 1'b1; hilo_sel = 1'b0;
        m_hi = '0; m_lo = '0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_lo", hilo_out, 32'd0);
        hilo_sel = 1'b1;
        #1 check("rst_hi", hilo_out, 32'd0);
        start = 1'b0; hilo_rd = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op("mult", 3'd0, 32'hffff_ffff, 32'd2);
        check("mult_hi_const", m_hi, 32'hffff_ffff);
        run_op("multu", 3'd1, 32'hffff_ffff, 32'd2);
        run_op("div", 3'd2, 32'hffff_fff9, 32'd2);
        run_op("divu0", 3'd3, 32'd7, 32'd0);
        run_op("divmin", 3'd2, 32'h8000_0000, 32'hffff_ffff);
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
        run_op("op6", 3'd6, 32'd3, 32'd4);

        stall_case(32'h0001_0003, 32'h0000_0007, 32'hcafe_f00d);

        // Accumulate sequence: HI=0, LO=0xFFFFFFFF, then MADD and MSUB of 1*1.
        run_op("mthi0", 3'd4, 32'd0, 32'd0);
        run_op("mtlo1s", 3'd5, 32'hffff_ffff, 32'd0);
        run_op("madd", 3'd6, 32'd1, 32'd1);
        run_op("msub", 3'd7, 32'd1, 32'd1);

        // Asynchronous reset in the middle of a DIV.
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        start = 1'b1; hilo_rd = 1'b1; hilo_sel = 1'b0;
        #1 check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_lo", hilo_out, 32'd0);
        hilo_sel = 1'b1;
        #1 check("mid_rst_hi", hilo_out, 32'd0);
        start = 1'b0; hilo_rd = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        run_op("post_rst_mult", 3'd0, 32'h8000_0001, 32'h7fff_fffe);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hffff_ffff; end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op("rand", ro, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
